// File: rtl/mips_mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS core: opcode/funct encodings,
// ALU operation and FSM state enums, and the one-hot instruction decode record.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef struct packed {
    logic alu_r;
    logic jr;
    logic j;
    logic jal;
    logic beq;
    logic addi;
    logic slti;
    logic lw;
    logic sw;
  } dec_t;

endpackage

// File: rtl/mips_mc_regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port; $0 always reads zero and ignores writes.
module mips_mc_regfile
  import mips_mc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core with a single req/ready memory port.
// Define MIPS_MC_JAL_EN to add jal/jr; otherwise both encode as illegal.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NREGS = 6'(NUM_REGS);
`ifdef MIPS_MC_JAL_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  state_e          state, state_nxt;
  logic [XLEN-1:0] pc, a, b, aluout, mdr, target;
  logic [31:0]     ir;
  logic            ill_q;

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  dec_t            dec;
  logic            legal;
  logic [XLEN-1:0] imm_sx, br_off, j_tgt;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign imm   = ir[15:0];
  assign funct = ir[5:0];

  assign imm_sx = {{(XLEN-16){imm[15]}}, imm};
  assign br_off = {imm_sx[XLEN-3:0], 2'b00};
  assign j_tgt  = {pc[XLEN-1:28], ir[25:0], 2'b00};

  always_comb begin
    dec       = '0;
    dec.alu_r = (op == OP_RTYPE) &&
                (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    dec.jr    = EXT_EN && (op == OP_RTYPE) && (funct == FN_JR);
    dec.j     = (op == OP_J);
    dec.jal   = EXT_EN && (NUM_REGS == 32) && (op == OP_JAL);
    dec.beq   = (op == OP_BEQ);
    dec.addi  = (op == OP_ADDI);
    dec.slti  = (op == OP_SLTI);
    dec.lw    = (op == OP_LW);
    dec.sw    = (op == OP_SW);
  end

  // Only register fields the instruction actually reads or writes are range-checked.
  logic uses_rs, uses_rt, rs_bad, rt_bad, rd_bad;
  assign uses_rs = dec.alu_r | dec.jr | dec.beq | dec.addi | dec.slti | dec.lw | dec.sw;
  assign uses_rt = dec.alu_r | dec.beq | dec.addi | dec.slti | dec.lw | dec.sw;
  assign rs_bad  = {1'b0, rs} >= NREGS;
  assign rt_bad  = {1'b0, rt} >= NREGS;
  assign rd_bad  = {1'b0, rd} >= NREGS;
  assign legal   = (dec != '0) && !(uses_rs && rs_bad) && !(uses_rt && rt_bad) &&
                   !(dec.alu_r && rd_bad);

  // ALU
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_b, alu_y;

  always_comb begin
    alu_op = ALU_ADD;
    if (dec.alu_r) begin
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (dec.slti) begin
      alu_op = ALU_SLT;
    end
  end

  assign alu_b = dec.alu_r ? b : imm_sx;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = a - alu_b;
      ALU_AND: alu_y = a & alu_b;
      ALU_OR:  alu_y = a | alu_b;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(alu_b)};
      default: alu_y = a + alu_b;
    endcase
  end

  // Register file; jal links in DECODE, everything else writes in WB.
  logic [XLEN-1:0] rd1, rd2, rf_wd;
  logic [AW-1:0]   rf_wa;
  logic            rf_we, link;

  assign link  = (state == DECODE) && dec.jal;
  assign rf_we = (state == WB) || link;
  assign rf_wa = link ? AW'(31) : (dec.alu_r ? rd[AW-1:0] : rt[AW-1:0]);
  assign rf_wd = link ? pc : (dec.lw ? mdr : aluout);

  mips_mc_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .AW(AW)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs[AW-1:0]),
    .ra2 (rt[AW-1:0]),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        if (!legal)                       state_nxt = HALT;
        else if (dec.j | dec.jal | dec.jr) state_nxt = FETCH;
        else                              state_nxt = EXEC;
      end
      EXEC: begin
        if (dec.lw | dec.sw) state_nxt = MEM;
        else if (dec.beq)    state_nxt = FETCH;
        else                 state_nxt = WB;
      end
      MEM:     if (mem_ready) state_nxt = dec.lw ? WB : FETCH;
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // FSM outputs: memory port is held steady by registered state until the ready edge.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = {pc[XLEN-1:2], 2'b00};
    case (state)
      FETCH: mem_req = 1'b1;
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = dec.sw;
        mem_wdata = dec.sw ? b : '0;
        mem_addr  = {aluout[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
    if (rst) mem_req = 1'b0;
  end

  assign halted  = (state == HALT);
  assign illegal = ill_q;
  assign pc_out  = pc;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
      target <= '0;
      ill_q  <= 1'b0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + XLEN'(4);
        end
        DECODE: begin
          a      <= rd1;
          b      <= rd2;
          target <= pc + br_off;
          if (!legal)                pc <= pc;
          else if (dec.j || dec.jal) pc <= j_tgt;
          else if (dec.jr)           pc <= rd1;
          if (!legal) ill_q <= 1'b1;
        end
        EXEC: begin
          aluout <= alu_y;
          if (dec.beq && a == b) pc <= target;
        end
        MEM: if (mem_ready && dec.lw) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: table of short store-terminated programs plus
// hand sequences for reset, fetch stall, beq/j redirect and illegal-instruction halt.
module tb_mips_mc_core;
  import mips_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  mips_mc_core #(.XLEN(32), .NUM_REGS(32), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .illegal   (illegal),
    .pc_out    (pc_out)
  );

  typedef struct {
    logic [5:0][31:0] prog;
    int               n;
    logic [31:0]      ea;
    logic [31:0]      ed;
    int               ec;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input int rd, input int rs,
                                        input int rt);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] w4, input int n,
                              input logic [31:0] ea, input logic [31:0] ed, input int ec);
    vec_t v;
    v.prog    = '0;
    v.prog[0] = w0;
    v.prog[1] = w1;
    v.prog[2] = w2;
    v.prog[3] = w3;
    v.prog[4] = w4;
    v.n       = n;
    v.ea      = ea;
    v.ed      = ed;
    v.ec      = ec;
    return v;
  endfunction

  task automatic load(input logic [5:0][31:0] p, input int n);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < n; i++) mem[i] = p[i];
    mem[60] = 32'hDEADBEEF;
  endtask

  // Two reset edges, released on a falling edge; caller is then in cycle 0.
  task automatic reset_release();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs until a store beat is seen; cyc counts cycles from first fetch to completion.
  task automatic run(input int max, output logic found, output logic [31:0] a,
                     output logic [31:0] d, output int cyc);
    found = 1'b0;
    a     = '0;
    d     = '0;
    cyc   = 0;
    for (int c = 0; c < max && !found; c++) begin
      #1;
      if (mem_req && mem_we && mem_ready) begin
        found = 1'b1;
        a     = mem_addr;
        d     = mem_wdata;
        cyc   = c + 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic halt_test(input string nm, input logic [31:0] w);
    logic [5:0][31:0] p;
    int bad;
    p    = '0;
    p[0] = w;
    load(p, 1);
    mem_ready = 1'b1;
    reset_release();
    repeat (2) @(negedge clk);
    #1;
    chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
    chk({nm, "_illegal"}, {31'd0, illegal}, 32'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (halted !== 1'b1 || illegal !== 1'b1 || mem_req !== 1'b0) bad++;
    end
    chk({nm, "_hold"}, 32'(bad), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk({nm, "_rst_halted"}, {31'd0, halted}, 32'd0);
    chk({nm, "_rst_illegal"}, {31'd0, illegal}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found;
    logic [31:0] sa, sd;
    int          cyc, k;
    logic [5:0][31:0] p;

    vt[0] = mk(itype(OP_ADDI,0,1,5), itype(OP_ADDI,0,2,7), rtype(FN_ADD,3,1,2),
               itype(OP_SW,0,3,32'h40), 0, 4, 32'h40, 32'd12, 16);
    vt[1] = mk(itype(OP_ADDI,0,1,5), itype(OP_ADDI,0,2,7), rtype(FN_SUB,3,1,2),
               itype(OP_SW,0,3,32'h44), 0, 4, 32'h44, 32'hFFFFFFFE, 16);
    vt[2] = mk(itype(OP_ADDI,0,1,12), itype(OP_ADDI,0,2,10), rtype(FN_AND,3,1,2),
               itype(OP_SW,0,3,32'h48), 0, 4, 32'h48, 32'd8, 16);
    vt[3] = mk(itype(OP_ADDI,0,1,12), itype(OP_ADDI,0,2,10), rtype(FN_OR,3,1,2),
               itype(OP_SW,0,3,32'h4C), 0, 4, 32'h4C, 32'hE, 16);
    vt[4] = mk(itype(OP_ADDI,0,1,-3), itype(OP_ADDI,0,2,2), rtype(FN_SLT,3,1,2),
               itype(OP_SW,0,3,32'h50), 0, 4, 32'h50, 32'd1, 16);
    vt[5] = mk(itype(OP_ADDI,0,1,-3), itype(OP_SLTI,1,3,-2), itype(OP_SW,0,3,32'h54),
               0, 0, 3, 32'h54, 32'd1, 12);
    vt[6] = mk(itype(OP_ADDI,0,1,2), itype(OP_ADDI,0,2,-3), rtype(FN_SLT,3,1,2),
               itype(OP_ADDI,3,3,7), itype(OP_SW,0,3,32'h58), 5, 32'h58, 32'd7, 20);
    vt[7] = mk(itype(OP_ADDI,0,0,9), itype(OP_LW,0,4,32'hF0), rtype(FN_ADD,4,4,0),
               itype(OP_SW,0,4,32'h80), 0, 4, 32'h80, 32'hDEADBEEF, 17);
    vt[8] = mk(itype(OP_ADDI,0,1,32'h100), itype(OP_LW,1,2,-16), itype(OP_SW,1,2,-144),
               0, 0, 3, 32'h70, 32'hDEADBEEF, 13);

    // Reset behaviour
    load(vt[0].prog, vt[0].n);
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_req0", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("rst_req1", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req", {31'd0, mem_req}, 32'd1);
    chk("rel_addr", mem_addr, 32'h0);
    chk("rel_we", {31'd0, mem_we}, 32'd0);
    chk("rel_halted", {31'd0, halted}, 32'd0);
    chk("rel_pc", pc_out, 32'h0);

    // Program table
    for (int i = 0; i < 9; i++) begin
      load(vt[i].prog, vt[i].n);
      mem_ready = 1'b1;
      reset_release();
      run(60, found, sa, sd, cyc);
      chk($sformatf("v%0d_found", i), {31'd0, found}, 32'd1);
      chk($sformatf("v%0d_addr", i), sa, vt[i].ea);
      chk($sformatf("v%0d_data", i), sd, vt[i].ed);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vt[i].ec));
    end

    // Fetch stall: three not-ready cycles, then ready
    load(vt[0].prog, vt[0].n);
    mem_ready = 1'b0;
    reset_release();
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("stall%0d_req", s), {31'd0, mem_req}, 32'd1);
      chk($sformatf("stall%0d_addr", s), mem_addr, 32'h0);
      chk($sformatf("stall%0d_pc", s), pc_out, 32'h0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("stall_adv_pc", pc_out, 32'h4);
    chk("stall_adv_req", {31'd0, mem_req}, 32'd0);
    run(60, found, sa, sd, cyc);
    chk("stall_total", 32'(4 + cyc), 32'd19);
    chk("stall_data", sd, 32'd12);

    // beq taken (back to 0x0C) and not taken (fall through to 0x14)
    for (int t = 0; t < 2; t++) begin
      p    = '0;
      p[0] = itype(OP_ADDI,0,1,3);
      p[1] = itype(OP_ADDI,0,2,4);
      p[2] = itype(OP_ADDI,0,3,1);
      p[3] = itype(OP_ADDI,0,3,2);
      p[4] = itype(OP_BEQ,1,(t == 0) ? 1 : 2,-2);
      load(p, 5);
      mem_ready = 1'b1;
      reset_release();
      repeat (16) @(negedge clk);
      #1;
      chk($sformatf("beq%0d_fetch", t), mem_addr, 32'h10);
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("beq%0d_req", t), {31'd0, mem_req}, 32'd1);
      chk($sformatf("beq%0d_next", t), mem_addr, (t == 0) ? 32'h0C : 32'h14);
    end

    // j: next fetch goes to the jump target
    p    = '0;
    p[0] = {OP_J, 26'h8};
    load(p, 1);
    mem_ready = 1'b1;
    reset_release();
    @(negedge clk);
    k = 0;
    #1;
    while (!mem_req && k < 4) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("j_req", {31'd0, mem_req}, 32'd1);
    chk("j_target", mem_addr, 32'h20);

    // Illegal encodings halt
    halt_test("op3f", 32'hFC000000);
    halt_test("nor", rtype(6'h27,3,1,2));
`ifndef MIPS_MC_JAL_EN
    halt_test("jal", {OP_JAL, 26'h4});
    halt_test("jr", rtype(FN_JR,0,1,0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
